// File: rtl/secand_pini_nk.sv
// N-share, K-bit masked AND gadget: two register stages (partial products, then
// share compression) with ready/valid flow control and a randomness-starvation counter.
module secand_pini_nk #(
  parameter int N  = 3,
  parameter int K  = 32,
  parameter int CW = 16,
  localparam int RW = N*(N-1)/2*K
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          i_dvld,
  input  logic          i_rvld,
  output logic          o_irdy,
  input  logic [RW-1:0] i_n,
  input  logic [N*K-1:0] i_x,
  input  logic [N*K-1:0] i_y,
  input  logic          i_ordy,
  output logic [N*K-1:0] o_c,
  output logic          o_dvld,
  output logic [CW-1:0] o_starve_cnt
);

  // Lexicographic index of unordered share pair {a,b}, a != b.
  function automatic int pair_idx(input int a, input int b);
    int lo;
    int hi;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    return lo*N - (lo*(lo+1))/2 + (hi - lo - 1);
  endfunction

  function automatic logic [K-1:0] cross_term(input logic [K-1:0] xi,
                                              input logic [K-1:0] yj,
                                              input logic [K-1:0] r);
    return (xi & yj) ^ r;
  endfunction

  logic          v1_q, v1_d;
  logic          v2_q, v2_d;
  logic [K-1:0]  q_q [N];
  logic [K-1:0]  q_d [N];
  logic [K-1:0]  u_q [N][N];
  logic [K-1:0]  u_d [N][N];
  logic [N*K-1:0] c_q, c_d;
  logic [CW-1:0] starve_q, starve_d;
  logic [K-1:0]  acc;
  logic          xfer;
  logic          adv1;

  assign adv1   = v1_q & (~v2_q | i_ordy);
  assign o_irdy = ~v1_q | adv1;
  assign xfer   = i_dvld & i_rvld & o_irdy;

  // Stage 1: inner and masked cross products, loaded only on an input transfer
  // so each randomness word is used exactly once. Diagonal u entries stay zero.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      q_d[i] = q_q[i];
      for (int j = 0; j < N; j++) begin
        u_d[i][j] = u_q[i][j];
      end
    end
    if (xfer) begin
      for (int i = 0; i < N; i++) begin
        q_d[i] = i_x[i*K +: K] & i_y[i*K +: K];
        for (int j = 0; j < N; j++) begin
          if (j != i) begin
            u_d[i][j] = cross_term(i_x[i*K +: K], i_y[j*K +: K],
                                   i_n[pair_idx(i, j)*K +: K]);
          end
        end
      end
    end
  end

  // Stage 2: compress registered terms into output shares; holds while stalled.
  always_comb begin
    c_d = c_q;
    acc = '0;
    if (adv1) begin
      for (int i = 0; i < N; i++) begin
        acc = q_q[i];
        for (int j = 0; j < N; j++) begin
          if (j != i) begin
            acc = acc ^ u_q[i][j];
          end
        end
        c_d[i*K +: K] = acc;
      end
    end
  end

  always_comb begin
    v1_d = v1_q;
    if (xfer) begin
      v1_d = 1'b1;
    end else if (adv1) begin
      v1_d = 1'b0;
    end

    v2_d = v2_q;
    if (adv1) begin
      v2_d = 1'b1;
    end else if (i_ordy) begin
      v2_d = 1'b0;
    end

    starve_d = starve_q;
    if (i_dvld && !i_rvld && (starve_q != {CW{1'b1}})) begin
      starve_d = starve_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      c_q      <= '0;
      starve_q <= '0;
      for (int i = 0; i < N; i++) begin
        q_q[i] <= '0;
        for (int j = 0; j < N; j++) begin
          u_q[i][j] <= '0;
        end
      end
    end else begin
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      c_q      <= c_d;
      starve_q <= starve_d;
      q_q      <= q_d;
      u_q      <= u_d;
    end
  end

  assign o_c          = c_q;
  assign o_dvld       = v2_q;
  assign o_starve_cnt = starve_q;

endmodule

// File: tb/tb_secand_pini_nk.sv
// Directed bench for secand_pini_nk (N=3, K=32): vector table, streaming,
// backpressure, starvation (CW=16 and CW=3) and mid-flight reset.
module tb_secand_pini_nk;

  logic        clk;
  logic        rst_ni;
  logic        i_dvld;
  logic        i_rvld;
  logic        o_irdy;
  logic [95:0] i_n;
  logic [95:0] i_x;
  logic [95:0] i_y;
  logic        i_ordy;
  logic [95:0] o_c;
  logic        o_dvld;
  logic [15:0] o_starve_cnt;

  logic        irdy_s;
  logic [95:0] c_s;
  logic        dvld_s;
  logic [2:0]  cnt_s;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [95:0] x;
    logic [95:0] y;
    logic [95:0] n;
    logic [95:0] c;
  } vec_t;

  vec_t vecs [4];
  logic [31:0] exp_q [$];

  secand_pini_nk #(.N(3), .K(32), .CW(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .i_dvld(i_dvld), .i_rvld(i_rvld),
    .o_irdy(o_irdy), .i_n(i_n), .i_x(i_x), .i_y(i_y), .i_ordy(i_ordy),
    .o_c(o_c), .o_dvld(o_dvld), .o_starve_cnt(o_starve_cnt)
  );

  secand_pini_nk #(.N(3), .K(32), .CW(3)) dut_s (
    .clk_i(clk), .rst_ni(rst_ni), .i_dvld(i_dvld), .i_rvld(i_rvld),
    .o_irdy(irdy_s), .i_n(i_n), .i_x(i_x), .i_y(i_y), .i_ordy(i_ordy),
    .o_c(c_s), .o_dvld(dvld_s), .o_starve_cnt(cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] xor3(input logic [95:0] v);
    return v[31:0] ^ v[63:32] ^ v[95:64];
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic dv, input logic rv, input logic [95:0] x,
                       input logic [95:0] y, input logic [95:0] n);
    i_dvld = dv;
    i_rvld = rv;
    i_x    = x;
    i_y    = y;
    i_n    = n;
  endtask

  task automatic single_op(input int idx, input string tag);
    drive(1'b1, 1'b1, vecs[idx].x, vecs[idx].y, vecs[idx].n);
    #1;
    check({tag, "_irdy"}, o_irdy, 1'b1);
    tick();
    drive(1'b0, 1'b0, '0, '0, '0);
    check({tag, "_dvld_lat1"}, o_dvld, 1'b0);
    tick();
    check({tag, "_dvld_lat2"}, o_dvld, 1'b1);
    check({tag, "_c"}, o_c, vecs[idx].c);
    check({tag, "_xor"}, xor3(o_c), xor3(vecs[idx].x) & xor3(vecs[idx].y));
  endtask

  initial begin
    int irdy_drops;
    int outs;
    logic [95:0] rx, ry, rn;

    // x, y, n, expected c; share 0 is the least-significant word
    vecs[0] = '{x: {32'h0, 32'h0, 32'hFFFFFFFF}, y: {32'h0, 32'h0, 32'h0F0F0F0F},
                n: 96'h0, c: {32'h0, 32'h0, 32'h0F0F0F0F}};
    vecs[1] = '{x: {32'h0, 32'h0, 32'hFFFFFFFF}, y: {32'h0, 32'h0, 32'h0F0F0F0F},
                n: {32'h0, 32'h0, 32'hA5A5A5A5}, c: {32'h0, 32'hA5A5A5A5, 32'hAAAAAAAA}};
    vecs[2] = '{x: {32'h0, 32'h0F0F0F0F, 32'hF0F0F0F0}, y: {32'h0, 32'h0, 32'hFFFFFFFF},
                n: {32'h0, 32'h12345678, 32'h0}, c: {32'h12345678, 32'h0F0F0F0F, 32'hE2C4A688}};
    vecs[3] = '{x: {32'h4, 32'h2, 32'h1}, y: {32'h6, 32'h5, 32'h3},
                n: {32'h20, 32'h10, 32'h8}, c: {32'h30, 32'h28, 32'h18}};

    rst_ni = 1'b0;
    i_ordy = 1'b1;
    drive(1'b0, 1'b0, '0, '0, '0);
    tick();
    tick();
    check("rst_dvld", o_dvld, 1'b0);
    check("rst_c", o_c, 96'h0);
    check("rst_cnt", o_starve_cnt, 16'h0);
    rst_ni = 1'b1;
    tick();
    check("post_rst_irdy", o_irdy, 1'b1);

    for (int i = 0; i < 4; i++) begin
      single_op(i, $sformatf("vec%0d", i));
    end
    check("vec3_small_c", c_s, vecs[3].c);

    // drain, then fill the pipe against a stalled consumer
    tick();
    check("idle_dvld", o_dvld, 1'b0);
    i_ordy = 1'b0;
    drive(1'b1, 1'b1, vecs[0].x, vecs[0].y, vecs[0].n);
    #1;
    check("bp_irdy_a", o_irdy, 1'b1);
    tick();
    drive(1'b1, 1'b1, vecs[3].x, vecs[3].y, vecs[3].n);
    #1;
    check("bp_irdy_b", o_irdy, 1'b1);
    tick();
    drive(1'b1, 1'b1, vecs[2].x, vecs[2].y, vecs[2].n);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_irdy_stall", o_irdy, 1'b0);
      check("bp_irdy_stall_s", irdy_s, 1'b0);
      check("bp_dvld_stall", o_dvld, 1'b1);
      check("bp_c_stall", o_c, vecs[0].c);
      tick();
    end
    i_ordy = 1'b1;
    drive(1'b0, 1'b0, '0, '0, '0);
    tick();
    check("bp_rel_dvld", o_dvld, 1'b1);
    check("bp_rel_c", o_c, vecs[3].c);
    tick();
    check("bp_drained_dvld", o_dvld, 1'b0);
    check("bp_retain_c", o_c, vecs[3].c);
    check("cnt_before_starve", o_starve_cnt, 16'h0);

    // starvation: operands offered without randomness
    drive(1'b1, 1'b0, vecs[1].x, vecs[1].y, vecs[1].n);
    for (int k = 0; k < 7; k++) begin
      tick();
      check("starve_dvld", o_dvld, 1'b0);
    end
    check("starve_cnt7", o_starve_cnt, 16'd7);
    check("starve_cnt7_s", cnt_s, 3'd7);
    tick();
    tick();
    check("starve_cnt9", o_starve_cnt, 16'd9);
    check("starve_sat_s", cnt_s, 3'd7);
    check("starve_dvld_s", dvld_s, 1'b0);
    drive(1'b0, 1'b1, '0, '0, '0);
    tick();
    check("rvld_only_cnt", o_starve_cnt, 16'd9);
    check("rvld_only_dvld", o_dvld, 1'b0);

    // reset while a result is presented and the counter is nonzero
    drive(1'b1, 1'b1, vecs[1].x, vecs[1].y, vecs[1].n);
    tick();
    drive(1'b0, 1'b0, '0, '0, '0);
    tick();
    check("mid_dvld_before", o_dvld, 1'b1);
    check("mid_c_before", o_c, vecs[1].c);
    #2;
    rst_ni = 1'b0;
    #1;
    check("mid_rst_dvld", o_dvld, 1'b0);
    check("mid_rst_c", o_c, 96'h0);
    check("mid_rst_cnt", o_starve_cnt, 16'h0);
    tick();
    rst_ni = 1'b1;
    single_op(2, "after_rst");

    // streaming: 100 back-to-back random operations
    tick();
    irdy_drops = 0;
    outs = 0;
    for (int cyc = 0; cyc < 110; cyc++) begin
      if (cyc < 100) begin
        rx = {$urandom(), $urandom(), $urandom()};
        ry = {$urandom(), $urandom(), $urandom()};
        rn = {$urandom(), $urandom(), $urandom()};
        drive(1'b1, 1'b1, rx, ry, rn);
        exp_q.push_back(xor3(rx) & xor3(ry));
        #1;
        if (o_irdy !== 1'b1) irdy_drops++;
      end else begin
        drive(1'b0, 1'b0, '0, '0, '0);
      end
      tick();
      if (o_dvld === 1'b1) begin
        outs++;
        if (exp_q.size() == 0) begin
          check("stream_extra_out", 1'b1, 1'b0);
        end else begin
          check($sformatf("stream_out%0d", outs), xor3(o_c), exp_q.pop_front());
        end
      end
    end
    check("stream_irdy_drops", irdy_drops, 0);
    check("stream_out_count", outs, 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/secand_pini_nk.md
Name: secand_pini_nk

Overview:
- Parametrised, pipelined masked AND gadget: N-share, K-bit Boolean-masked operands x, y → N-share masking of x&y.
- Generalises the fixed 3-share/32-bit SecAnd gadget to arbitrary share count and width.
- Adds ready/valid backpressure, exactly-once randomness consumption under stall, and a randomness-starvation counter.
- Sits in the B2A datapath between the masked-adder stages.

Parameters:
- N, 3, number of shares (≥2).
- K, 32, bits per share.
- CW, 16, width of starvation counter.
- Derived: RW = N*(N-1)/2*K, randomness bus width (96 at defaults).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- i_dvld  in  1  input operands valid.
- i_rvld  in  1  randomness valid.
- o_irdy  out  1  gadget can accept; input transfer = i_dvld & i_rvld & o_irdy.
- i_n  in  RW  fresh randomness; pair p occupies bits [p*K +: K].
- i_x  in  N*K  x shares; share s at [s*K +: K].
- i_y  in  N*K  y shares, same packing.
- i_ordy  in  1  downstream ready.
- o_c  out  N*K  output shares, same packing.
- o_dvld  out  1  o_c valid; output transfer = o_dvld & i_ordy.
- o_starve_cnt  out  CW  saturating count of cycles with i_dvld=1, i_rvld=0.

Behaviour:
- Reset (async, rst_ni=0): v1=v2=0, o_dvld=0, o_c=0, all stage-1 registers 0, o_starve_cnt=0. o_irdy=1 the first cycle after release.
- Pair index p for i<j is lexicographic: (0,1)=0, (0,2)=1, …, (N-2,N-1)=last. r_ij = r_ji = i_n[p*K +: K].
- Stage 1, registered on input transfer:
  - inner term q_i = x_i & y_i.
  - cross terms u_ij = (x_i & y_j) ^ r_ij for all i≠j.
  - v1 ← 1.
- Stage 2, registered on stage-1 advance: o_c share i = q_i ^ XOR over j≠i of u_ij; o_dvld ← 1.
  - Compression acts only on registered terms; no combinational path from i_x, i_y or i_n to o_c.
- Latency: 2 cycles from input transfer to o_dvld, with no stall. Throughput: 1 operation per cycle.
- Stage-1 advance condition: adv1 = v1 & (!v2 | i_ordy).
- o_irdy = !v1 | adv1 (combinational).
- v1 next state:
  - 1 if input transfer occurs;
  - else 0 if adv1;
  - else hold.
- v2 next state:
  - 1 if adv1;
  - else 0 if i_ordy;
  - else hold.
- Stall rules:
  - While o_dvld=1 and i_ordy=0, o_c holds unchanged.
  - Stage-1 registers load only on input transfer, never on idle or stalled cycles, so each randomness word is consumed exactly once.
  - i_n must not be sampled unless a transfer occurs.
- Partial handshakes:
  - i_dvld=1, i_rvld=0: no transfer; o_starve_cnt increments, saturating at 2^CW-1.
  - i_rvld=1, i_dvld=0: no transfer; counter unchanged.
- Simultaneous events: new input transfer, stage-1 advance and output drain in the same cycle are all legal; the pipeline stays full.
- o_c after drain retains its last value; only o_dvld qualifies it.
- Correctness invariant: XOR of o_c shares = (XOR of x shares) & (XOR of y shares), for any i_n.
- Reset mid-operation: in-flight data is discarded and o_dvld drops asynchronously.

Test Plan:
- Single op, r=0 (N=3, K=32): x shares {FFFFFFFF,0,0}, y shares {0F0F0F0F,0,0}, i_n=0 → o_dvld 2 cycles after transfer; o_c shares {0F0F0F0F,0,0}.
- Same operands, pair(0,1)=A5A5A5A5, other pairs 0 → o_c shares {AAAAAAAA,A5A5A5A5,00000000}; XOR = 0F0F0F0F.
- Streaming: 100 back-to-back random transfers with i_ordy=1 → o_irdy stays 1; 100 outputs in order; each share-XOR equals the unmasked AND.
- Backpressure: hold i_ordy=0 for 5 cycles with the pipe full → o_irdy=0 after 2 accepted ops; o_c stable; no further transfers. Release → both results emerge in order.
- Starvation: i_dvld=1, i_rvld=0 for 7 cycles → o_starve_cnt=7, no output. With CW=3, 9 such cycles → saturates at 7.
- Reset mid-flight: assert rst_ni low one cycle after a transfer → o_dvld=0, o_c=0, counter 0 immediately. The next op after release completes with latency 2.
